// File: rtl/ps_pkg.sv
// Shared definitions for the program-sequencer interrupt controller:
// vector base, register address map and FSM state encoding.
package ps_pkg;

   localparam int          NUM_IRQ   = 4;
   localparam logic [15:0] VECT_BASE = 16'h0040;

   typedef enum logic [1:0] {
      ADDR_IMASK  = 2'b00,
      ADDR_IRPTL  = 2'b01,
      ADDR_IMASKP = 2'b10,
      ADDR_ICTL   = 2'b11
   } ic_addr_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_REQ   = 2'b01,
      S_FLUSH = 2'b10
   } ic_state_e;

endpackage

// File: rtl/ic_prio_enc.sv
// Fixed-priority encoder: returns the lowest set bit index of req, vld when any bit is set.
module ic_prio_enc (
   input  logic [3:0] req,
   output logic [1:0] idx,
   output logic       vld
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      idx = 2'd0;
      vld = |req;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) idx = 2'(i);
      end
   end

endmodule

// File: rtl/ps_int_ctrl.sv
// Interrupt controller for the program sequencer: edge-latched requests, masking,
// strict-priority nesting via IMASKP, and a request/ack/flush handshake.
module ps_int_ctrl
   import ps_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  irq,
   input  logic        ps_ic_ack,
   input  logic        ps_ic_rti,
   input  logic        ps_ic_wrt_en,
   input  logic [1:0]  ps_ic_wrt_add,
   input  logic [15:0] bc_dt,
   input  logic [1:0]  ps_ic_rd_add,
   output logic [15:0] ic_ps_rd_dt,
   output logic        ic_ps_req,
   output logic [15:0] ic_ps_vect,
   output logic        ic_ps_wake,
   output logic        ic_ps_busy
);

   ic_state_e  state_q, state_d;
   logic [3:0] irq_q, irq_d;
   logic       arm_q, arm_d;
   logic [3:0] imask_q, imask_d;
   logic [3:0] irptl_q, irptl_d;
   logic [3:0] imaskp_q, imaskp_d;
   logic       gie_q, gie_d;
   logic [1:0] win_idx_q, win_idx_d;
   logic       flush_cnt_q, flush_cnt_d;

   logic [3:0] irq_edge, pend, blocked, eligible;
   logic [1:0] win_sel, rti_idx;
   logic       win_vld, rti_vld, ack_take;
   logic [3:0] wdat, rd4;
   logic       bc_dt_unused;

   assign bc_dt_unused = ^bc_dt[15:4];
   assign wdat         = bc_dt[3:0];

   // arm_q suppresses the edge detector for the first cycle after reset, so a line
   // already high at release is treated as old, not as a new request.
   assign irq_edge = irq & ~irq_q & {4{arm_q}};
   assign pend     = irptl_q & imask_q & {4{gie_q}};
   assign eligible = pend & ~blocked;
   assign ack_take = ps_ic_ack && (state_q == S_REQ);

   always_comb begin
      blocked = 4'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         blocked[i] = |(imaskp_q & 4'((1 << (i + 1)) - 1));
      end
   end

   ic_prio_enc u_win_enc (.req(eligible), .idx(win_sel), .vld(win_vld));
   ic_prio_enc u_rti_enc (.req(imaskp_q), .idx(rti_idx), .vld(rti_vld));

   always_comb begin
      irq_d    = irq;
      arm_d    = 1'b1;
      imask_d  = imask_q;
      gie_d    = gie_q;
      irptl_d  = irptl_q;
      imaskp_d = imaskp_q;

      if (ps_ic_wrt_en) begin
         case (ps_ic_wrt_add)
            ADDR_IMASK:  imask_d  = wdat;
            ADDR_IRPTL:  irptl_d  = wdat;
            ADDR_IMASKP: imaskp_d = wdat;
            ADDR_ICTL:   gie_d    = wdat[0];
            default:     ;
         endcase
      end

      // Hardware edges win over software writes and the ack clear of the same bit.
      if (ack_take) irptl_d[win_idx_q] = 1'b0;
      irptl_d = irptl_d | irq_edge;

      // RTI clear uses the pre-ack IMASKP; the ack set is applied afterwards.
      if (ps_ic_rti && rti_vld) imaskp_d[rti_idx] = 1'b0;
      if (ack_take) imaskp_d[win_idx_q] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      win_idx_d   = win_idx_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d   = S_REQ;
               win_idx_d = win_sel;
            end
         end
         S_REQ: begin
            if (ps_ic_ack) begin
               state_d     = S_FLUSH;
               flush_cnt_d = 1'b0;
            end
         end
         S_FLUSH: begin
            if (flush_cnt_q) state_d = S_IDLE;
            else             flush_cnt_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q     <= S_IDLE;
         irq_q       <= 4'b0;
         arm_q       <= 1'b0;
         imask_q     <= 4'b0;
         irptl_q     <= 4'b0;
         imaskp_q    <= 4'b0;
         gie_q       <= 1'b0;
         win_idx_q   <= 2'd0;
         flush_cnt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         irq_q       <= irq_d;
         arm_q       <= arm_d;
         imask_q     <= imask_d;
         irptl_q     <= irptl_d;
         imaskp_q    <= imaskp_d;
         gie_q       <= gie_d;
         win_idx_q   <= win_idx_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      ic_ps_req  = (state_q == S_REQ);
      ic_ps_busy = (state_q != S_IDLE);
      ic_ps_vect = VECT_BASE + {12'b0, win_idx_q, 2'b00};
      ic_ps_wake = |(irptl_q & imask_q);
   end

   always_comb begin
      rd4 = 4'b0;
      case (ps_ic_rd_add)
         ADDR_IMASK:  rd4 = imask_q;
         ADDR_IRPTL:  rd4 = irptl_q;
         ADDR_IMASKP: rd4 = imaskp_q;
         ADDR_ICTL:   rd4 = {3'b0, gie_q};
         default:     ;
      endcase
      if (ps_ic_wrt_en && (ps_ic_wrt_add == ps_ic_rd_add)) rd4 = wdat;
      ic_ps_rd_dt = {12'b0, rd4};
   end

endmodule
